interleaver_block_scheduler: RTL and testbench

Sequences whole code blocks from a synchronous byte ROM into the TurboInterleaver. It accepts block jobs (start address plus short/long size) from a requester and drives the ROM address. It also runs the `look_now_in`/`flag_long_in`/`dataInNext` handshake toward the interleaver, then waits for the interleaver's output burst to finish before reporting completion. It replaces free-running bring-up sequencing with a reusable job-based controller for board tests and the system datapath.

---
 rtl/interleaver_block_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_interleaver_block_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interleaver_block_scheduler.sv
// interleaver_block_scheduler: feeds whole code blocks from a byte ROM into
// the TurboInterleaver and waits for its output burst before signalling done.
//
// Ports:
//   clk, reset_async (async, active-low)
//   req_valid/req_long/req_base/req_ready : block job request
//   rom_addr                              : ROM byte address (1-cycle read)
//   data_in_next                          : interleaver byte consume strobe
//   look_now_in/flag_long_in              : input window / size select out
//   look_now_out                          : interleaver output burst active
//   busy/blk_done/blk_count/err_timeout   : status
//
// Optional build macro SCHED_TIMEOUT_EN adds a WAIT_OUT watchdog that forces
// completion after TIMEOUT_CYCLES and raises a sticky err_timeout.

module interleaver_block_scheduler #(
  parameter int ADDR_W         = 10,
  parameter int K_SHORT        = 132,
  parameter int K_LONG         = 768,
  parameter int GUARD_CYCLES   = 500,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic              clk,
  input  logic              reset_async,
  input  logic              req_valid,
  input  logic              req_long,
  input  logic [ADDR_W-1:0] req_base,
  output logic              req_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              data_in_next,
  output logic              look_now_in,
  output logic              flag_long_in,
  input  logic              look_now_out,
  output logic              busy,
  output logic              blk_done,
  output logic [7:0]        blk_count,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    GUARD,
    IDLE,
    FEED,
    WAIT_OUT,
    DONE
  } state_t;

  localparam logic [9:0] GUARD_LAST = 10'(GUARD_CYCLES - 1);
  localparam logic [9:0] SHORT_LAST = 10'(K_SHORT - 1);
  localparam logic [9:0] LONG_LAST  = 10'(K_LONG - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic [9:0]        guard_cnt;
  logic [9:0]        offset;
  logic [9:0]        k_last;
  logic              long_q;
  logic              seen_out;
  logic              req_ready_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              look_now_in_q;
  logic              flag_long_q;
  logic              busy_q;
  logic              blk_done_q;
  logic [7:0]        blk_count_q;

  logic              burst_end;
  logic              wd_hit;

  // A burst has finished once it was seen high and is now low again.
  assign burst_end = seen_out && !look_now_out;

`ifdef SCHED_TIMEOUT_EN
  localparam logic [11:0] WD_LAST = 12'(TIMEOUT_CYCLES - 1);

  logic [11:0] wd_cnt;
  logic        err_q;

  assign wd_hit = (state == WAIT_OUT) && (wd_cnt == WD_LAST);

  // Counter is held at zero outside WAIT_OUT, so it restarts on entry.
  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state != WAIT_OUT) begin
        wd_cnt <= '0;
      end else if (!wd_hit) begin
        wd_cnt <= wd_cnt + 12'd1;
      end
      if (wd_hit && !burst_end) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign wd_hit             = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      state         <= GUARD;
      guard_cnt     <= '0;
      offset        <= '0;
      k_last        <= '0;
      long_q        <= 1'b0;
      seen_out      <= 1'b0;
      req_ready_q   <= 1'b0;
      rom_addr_q    <= '0;
      look_now_in_q <= 1'b0;
      flag_long_q   <= 1'b0;
      busy_q        <= 1'b0;
      blk_done_q    <= 1'b0;
      blk_count_q   <= '0;
    end else begin
      blk_done_q <= 1'b0;
      unique case (state)
        GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
          end else begin
            guard_cnt <= guard_cnt + 10'd1;
          end
        end
        IDLE: begin
          if (req_valid) begin
            state         <= FEED;
            req_ready_q   <= 1'b0;
            long_q        <= req_long;
            rom_addr_q    <= req_base;
            offset        <= '0;
            k_last        <= req_long ? LONG_LAST : SHORT_LAST;
            look_now_in_q <= 1'b1;
            flag_long_q   <= req_long;
            busy_q        <= 1'b1;
          end
        end
        FEED: begin
          if (data_in_next) begin
            if (offset == k_last) begin
              // Address stays on the last byte of the block.
              state         <= WAIT_OUT;
              look_now_in_q <= 1'b0;
              seen_out      <= 1'b0;
            end else begin
              offset     <= offset + 10'd1;
              rom_addr_q <= rom_addr_q + ADDR_ONE;
            end
          end
        end
        WAIT_OUT: begin
          flag_long_q <= long_q;
          if (look_now_out) begin
            seen_out <= 1'b1;
          end
          if (burst_end || wd_hit) begin
            state       <= DONE;
            blk_done_q  <= 1'b1;
            blk_count_q <= blk_count_q + 8'd1;
            flag_long_q <= 1'b0;
          end
        end
        DONE: begin
          state       <= IDLE;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state <= GUARD;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign rom_addr     = rom_addr_q;
  assign look_now_in  = look_now_in_q;
  assign flag_long_in = flag_long_q;
  assign busy         = busy_q;
  assign blk_done     = blk_done_q;
  assign blk_count    = blk_count_q;

endmodule

// File: tb/tb_interleaver_block_scheduler.sv
// tb_interleaver_block_scheduler: directed self-checking bench for the
// interleaver block scheduler (guard, short/long jobs, back-to-back, reset).

module tb_interleaver_block_scheduler;

  logic       clk = 1'b0;
  logic       reset_async = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_long = 1'b0;
  logic [9:0] req_base = '0;
  logic       req_ready;
  logic [9:0] rom_addr;
  logic       data_in_next = 1'b0;
  logic       look_now_in;
  logic       flag_long_in;
  logic       look_now_out = 1'b0;
  logic       busy;
  logic       blk_done;
  logic [7:0] blk_count;
  logic       err_timeout;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  interleaver_block_scheduler #(
    .ADDR_W(10),
    .K_SHORT(132),
    .K_LONG(768),
    .GUARD_CYCLES(500),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .reset_async(reset_async),
    .req_valid(req_valid),
    .req_long(req_long),
    .req_base(req_base),
    .req_ready(req_ready),
    .rom_addr(rom_addr),
    .data_in_next(data_in_next),
    .look_now_in(look_now_in),
    .flag_long_in(flag_long_in),
    .look_now_out(look_now_out),
    .busy(busy),
    .blk_done(blk_done),
    .blk_count(blk_count),
    .err_timeout(err_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_guard(output int rise);
    rise = -1;
    for (int n = 1; n <= 600; n++) begin
      step();
      if (req_ready === 1'b1) begin
        rise = n;
        break;
      end
    end
  endtask

  task automatic do_feed(
    input  logic [9:0] base,
    input  logic       lng,
    input  bit         toggle,
    input  bit         hold,
    output int         accepted,
    output int         high,
    output int         addr_errs,
    output int         side_errs,
    output logic [9:0] last_addr
  );
    int k;
    int cyc;
    bit dn;
    logic [9:0] exp_a;
    k = lng ? 768 : 132;
    req_valid = 1'b1;
    req_long  = lng;
    req_base  = base;
    for (int n = 0; n < 2000 && req_ready !== 1'b1; n++) step();
    step();
    if (!hold) req_valid = 1'b0;
    exp_a = base;
    accepted = 0;
    high = 0;
    addr_errs = 0;
    side_errs = 0;
    cyc = 0;
    while (look_now_in === 1'b1 && high < 4000) begin
      high++;
      if (rom_addr !== exp_a) addr_errs++;
      if (flag_long_in !== lng || busy !== 1'b1 ||
          req_ready !== 1'b0 || blk_done !== 1'b0) side_errs++;
      dn = toggle ? (cyc % 2 == 0) : 1'b1;
      data_in_next = dn;
      step();
      if (dn) begin
        accepted++;
        if (accepted < k) exp_a = exp_a + 10'd1;
      end
      cyc++;
    end
    data_in_next = 1'b0;
    last_addr = rom_addr;
  endtask

  task automatic do_burst(
    input  int   gap,
    input  int   len,
    input  logic lng,
    output int   side_errs,
    output bit   done_ok
  );
    side_errs = 0;
    for (int i = 0; i < gap; i++) begin
      if (blk_done !== 1'b0 || look_now_in !== 1'b0 ||
          flag_long_in !== lng || busy !== 1'b1) side_errs++;
      step();
    end
    look_now_out = 1'b1;
    for (int i = 0; i < len; i++) begin
      step();
      if (blk_done !== 1'b0 || flag_long_in !== lng ||
          busy !== 1'b1) side_errs++;
    end
    look_now_out = 1'b0;
    step();
    done_ok = (blk_done === 1'b1);
  endtask

  task automatic run_job(
    input string      tag,
    input logic [9:0] base,
    input logic       lng,
    input bit         toggle,
    input bit         hold,
    input int         exp_high,
    input logic [9:0] exp_last
  );
    int acc, high, aerr, serr, berr, k;
    bit done_ok;
    logic [9:0] last;
    k = lng ? 768 : 132;
    do_feed(base, lng, toggle, hold, acc, high, aerr, serr, last);
    checks++;
    if (acc !== k) begin
      errors++;
      $display("FAIL %s_accepted: got %0d expected %0d", tag, acc, k);
    end
    checks++;
    if (high !== exp_high) begin
      errors++;
      $display("FAIL %s_window: got %0d expected %0d", tag, high, exp_high);
    end
    checks++;
    if (aerr !== 0 || serr !== 0) begin
      errors++;
      $display("FAIL %s_feed: got addr_errs=%0d side_errs=%0d expected 0 0",
               tag, aerr, serr);
    end
    checks++;
    if (last !== exp_last) begin
      errors++;
      $display("FAIL %s_last_addr: got %0d expected %0d", tag, last, exp_last);
    end
    do_burst(3, 10, lng, berr, done_ok);
    exp_count++;
    checks++;
    if (berr !== 0 || done_ok !== 1'b1) begin
      errors++;
      $display("FAIL %s_burst: got errs=%0d done=%0d expected 0 1",
               tag, berr, done_ok);
    end
    checks++;
    if (blk_count !== 8'(exp_count) || flag_long_in !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: got cnt=%0d flag=%b busy=%b expected %0d 0 1",
               tag, blk_count, flag_long_in, busy, exp_count);
    end
    step();
    checks++;
    if (req_ready !== 1'b1 || blk_done !== 1'b0 ||
        busy !== 1'b0 || look_now_in !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got rdy=%b done=%b busy=%b lni=%b expected 1 0 0 0",
               tag, req_ready, blk_done, busy, look_now_in);
    end
  endtask

  task automatic test_reset();
    int rise;
    reset_async = 1'b0;
    repeat (3) step();
    checks++;
    if ({rom_addr, req_ready, look_now_in, flag_long_in, busy,
         blk_done, blk_count, err_timeout} !== 24'h0) begin
      errors++;
      $display("FAIL reset_values: got %h expected 000000",
               {rom_addr, req_ready, look_now_in, flag_long_in, busy,
                blk_done, blk_count, err_timeout});
    end
    reset_async = 1'b1;
    wait_guard(rise);
    checks++;
    if (rise !== 500) begin
      errors++;
      $display("FAIL guard_ready: got %0d expected 500", rise);
    end
    checks++;
    if (busy !== 1'b0 || look_now_in !== 1'b0 || blk_count !== 8'd0 ||
        rom_addr !== 10'd0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL guard_outputs: got busy=%b lni=%b cnt=%0d addr=%0d err=%b expected 0 0 0 0 0",
               busy, look_now_in, blk_count, rom_addr, err_timeout);
    end
  endtask

  task automatic test_short_job();
    run_job("short", 10'd0, 1'b0, 1'b0, 1'b0, 132, 10'd131);
  endtask

  task automatic test_long_wrap();
    run_job("long", 10'd1000, 1'b1, 1'b1, 1'b0, 1535, 10'd743);
  endtask

  task automatic test_back_to_back();
    run_job("b2b_1", 10'd300, 1'b0, 1'b0, 1'b1, 132, 10'd431);
    checks++;
    if (req_valid !== 1'b1 || look_now_in !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: got valid=%b lni=%b expected 1 0",
               req_valid, look_now_in);
    end
    run_job("b2b_2", 10'd20, 1'b1, 1'b0, 1'b0, 768, 10'd787);
  endtask

  task automatic test_mid_reset();
    int rise;
    req_valid = 1'b1;
    req_long  = 1'b1;
    req_base  = 10'd200;
    for (int n = 0; n < 2000 && req_ready !== 1'b1; n++) step();
    step();
    req_valid = 1'b0;
    data_in_next = 1'b1;
    repeat (50) step();
    checks++;
    if (rom_addr !== 10'd250 || look_now_in !== 1'b1 ||
        blk_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL midrst_pre: got addr=%0d lni=%b cnt=%0d expected 250 1 %0d",
               rom_addr, look_now_in, blk_count, exp_count);
    end
    #2;
    reset_async = 1'b0;
    #1;
    checks++;
    if (look_now_in !== 1'b0 || busy !== 1'b0 || blk_count !== 8'd0 ||
        rom_addr !== 10'd0 || flag_long_in !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got lni=%b busy=%b cnt=%0d addr=%0d flag=%b expected 0 0 0 0 0",
               look_now_in, busy, blk_count, rom_addr, flag_long_in);
    end
    data_in_next = 1'b0;
    exp_count = 0;
    repeat (2) step();
    reset_async = 1'b1;
    wait_guard(rise);
    checks++;
    if (rise !== 500 || blk_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst_guard: got rise=%0d cnt=%0d expected 500 0",
               rise, blk_count);
    end
  endtask

  task automatic test_timeout();
    int acc, high, aerr, serr, done_at;
    logic [9:0] last;
    do_feed(10'd5, 1'b0, 1'b0, 1'b0, acc, high, aerr, serr, last);
    checks++;
    if (acc !== 132 || look_now_in !== 1'b0) begin
      errors++;
      $display("FAIL to_feed: got acc=%0d lni=%b expected 132 0", acc, look_now_in);
    end
    done_at = -1;
    for (int n = 1; n <= 300; n++) begin
      step();
      if (blk_done === 1'b1) begin
        done_at = n;
        break;
      end
    end
`ifdef SCHED_TIMEOUT_EN
    exp_count++;
    checks++;
    if (done_at !== 100 || err_timeout !== 1'b1 ||
        blk_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL to_fire: got at=%0d err=%b cnt=%0d expected 100 1 %0d",
               done_at, err_timeout, blk_count, exp_count);
    end
    step();
    checks++;
    if (err_timeout !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: got err=%b rdy=%b expected 1 1",
               err_timeout, req_ready);
    end
`else
    checks++;
    if (done_at !== -1 || err_timeout !== 1'b0 || busy !== 1'b1 ||
        blk_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL to_none: got at=%0d err=%b busy=%b cnt=%0d expected -1 0 1 %0d",
               done_at, err_timeout, busy, blk_count, exp_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_short_job();
    test_long_wrap();
    test_back_to_back();
    test_mid_reset();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
